// File: rtl/sio_pkg.sv
// rtl/sio_pkg.sv - shared constants for the SIO byte-level serial port
package sio_pkg;

  localparam int DEF_DATA_BITS = 8;
  localparam int TICKS_PER_BIT = 2;
  localparam int BIT_CNT_W     = $clog2(DEF_DATA_BITS + 1);

  // tick-within-bit counter
  localparam int              PH_W    = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TICKS_PER_BIT - 1);

  // shared by the TX and RX state machines
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/sio_sync_edge.sv
// rtl/sio_sync_edge.sv - synchronisers for sio_clk (with rise pulse) and rxd (level only)
module sio_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic edge_in,
  input  logic level_in,
  output logic rise,
  output logic level
);

  logic [STAGES-1:0] edge_sync;
  logic [STAGES-1:0] level_sync;
  logic              edge_q;

  // rxd chain resets to the idle-high line level so reset release is not a start bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_sync  <= '0;
      level_sync <= '1;
      edge_q     <= 1'b0;
      rise       <= 1'b0;
    end else begin
      edge_sync  <= {edge_sync[STAGES-2:0], edge_in};
      level_sync <= {level_sync[STAGES-2:0], level_in};
      edge_q     <= edge_sync[STAGES-1];
      rise       <= edge_sync[STAGES-1] & ~edge_q;
    end
  end

  assign level = level_sync[STAGES-1];

endmodule

// File: rtl/sio_uart.sv
// rtl/sio_uart.sv - 8N1 serial port timed by half-bit ticks from the SIO clock divider
module sio_uart
  import sio_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 sio_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int            CW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  logic tick;
  logic rxd_s;

  sio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .n_rst    (n_rst),
    .edge_in  (sio_clk),
    .level_in (rxd),
    .rise     (tick),
    .level    (rxd_s)
  );

  logic [1:0]           tx_state;
  logic [PH_W-1:0]      tx_phase;
  logic [CW-1:0]        tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;

  assign tx_ready = (tx_state == ST_IDLE);

  // a bit level is driven on the first tick of each bit; the state advances on its last tick
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_state <= ST_IDLE;
      tx_phase <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else if (tx_state == ST_IDLE) begin
      if (tx_valid) begin
        tx_shift <= tx_data;
        tx_phase <= '0;
        tx_state <= ST_START;
      end
    end else if (tick) begin
      tx_phase <= (tx_phase == PH_LAST) ? '0 : tx_phase + 1'b1;
      if (tx_phase == '0) begin
        case (tx_state)
          ST_START: txd <= 1'b0;
          ST_DATA: begin
            txd      <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          default:  txd <= 1'b1;
        endcase
      end
      if (tx_phase == PH_LAST) begin
        case (tx_state)
          ST_START: begin
            tx_cnt   <= '0;
            tx_state <= ST_DATA;
          end
          ST_DATA: begin
            if (tx_cnt == LAST_BIT) tx_state <= ST_STOP;
            else                    tx_cnt   <= tx_cnt + 1'b1;
          end
          default:  tx_state <= ST_IDLE;
        endcase
      end
    end
  end

  logic [1:0]           rx_state;
  logic [PH_W-1:0]      rx_phase;
  logic [CW-1:0]        rx_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_done;

  assign rx_done = tick && (rx_state == ST_STOP) && (rx_phase == PH_LAST);

  // START is one tick after the falling edge was seen, so samples land late in each bit
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_state <= ST_IDLE;
      rx_phase <= '0;
      rx_cnt   <= '0;
      rx_shift <= '0;
    end else if (tick) begin
      case (rx_state)
        ST_IDLE: begin
          if (!rxd_s) rx_state <= ST_START;
        end
        ST_START: begin
          if (!rxd_s) begin
            rx_phase <= '0;
            rx_cnt   <= '0;
            rx_state <= ST_DATA;
          end else begin
            rx_state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + 1'b1;
          if (rx_phase == PH_LAST) begin
            rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
            if (rx_cnt == LAST_BIT) rx_state <= ST_STOP;
            else                    rx_cnt   <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + 1'b1;
          if (rx_phase == PH_LAST) rx_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else if (rx_done) begin
      rx_data      <= rx_shift;
      rx_valid     <= 1'b1;
      rx_frame_err <= ~rxd_s;
      rx_overrun   <= rx_valid & ~rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sio_uart.sv
// tb/tb_sio_uart.sv - directed self-checking bench for sio_uart
module tb_sio_uart;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       sio_clk = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       rx_frame_err;
  logic       rx_overrun;

  logic stall = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   s, c, d, n, sb;

  sio_uart dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .sio_clk      (sio_clk),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .txd          (txd),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // half-bit timebase: toggles every 4 clk, one tick every 8 clk
  always begin
    repeat (4) @(negedge clk);
    if (!stall) sio_clk = ~sio_clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tx_accept(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", tx_ready, 1'b0);
    check("txd_high_after_accept", txd, 1'b1);
  endtask

  task automatic wait_txd_fall(output int w);
    w = 0;
    while (txd !== 1'b0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("tx_start_seen", txd, 1'b0);
  endtask

  // t=0 is the first negedge with txd low; bit i is sampled mid-bit at 16*i+8
  task automatic chk_tx_frame(input logic [7:0] b, input logic noise, output int w);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    wait_txd_fall(w);
    for (int t = 0; t <= 152; t++) begin
      if (t % 16 == 8) check($sformatf("tx_%0h_bit%0d", b, t / 16), txd, f[t/16]);
      if (t == 151) check("tx_ready_before_end", tx_ready, 1'b0);
      if (t == 152) check("tx_ready_after_stop", tx_ready, 1'b1);
      if (noise && t % 16 == 4) begin
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
      if (noise && t % 16 == 5) tx_valid = 1'b0;
      if (t < 152) @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop, output int sc);
    logic [9:0] f;
    f  = {stop, b, 1'b0};
    sc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (16) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic rx_wait_valid(output int cv);
    cv = -1;
    for (int k = 0; k < 400 && cv < 0; k++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) cv = cyc;
    end
  endtask

  task automatic rx_ack_pulse;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_frame_err", rx_frame_err, 1'b0);
    check("rst_rx_overrun", rx_overrun, 1'b0);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);

    // T1
    tx_accept(8'h55);
    chk_tx_frame(8'h55, 1'b0, n);
    check("t1_start_latency", (n >= 1 && n <= 8), 1'b1);

    // T2: tx_valid held high across the first frame
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    @(negedge clk);
    check("t2_first_accept", tx_ready, 1'b0);
    tx_data = 8'h0F;
    chk_tx_frame(8'hA3, 1'b0, n);
    @(negedge clk);
    check("t2_second_accept", tx_ready, 1'b0);
    tx_valid = 1'b0;
    chk_tx_frame(8'h0F, 1'b0, n);
    check("t2_contiguous", n, 7);

    tx_accept(8'h5A);
    chk_tx_frame(8'h5A, 1'b1, n);
    repeat (40) @(negedge clk);
    check("t2_busy_not_queued_txd", txd, 1'b1);
    check("t2_busy_not_queued_ready", tx_ready, 1'b1);

    // T3: every phase of the frame start against the tick
    for (int off = 0; off < 8; off++) begin
      while (cyc % 8 != off) @(negedge clk);
      fork
        send_rx(8'hC4, 1'b1, s);
        rx_wait_valid(c);
      join
      check($sformatf("t3_seen_off%0d", off), (c >= 0), 1'b1);
      check($sformatf("t3_data_off%0d", off), rx_data, 8'hC4);
      check($sformatf("t3_ferr_off%0d", off), rx_frame_err, 1'b0);
      rx_ack_pulse();
      check($sformatf("t3_cleared_off%0d", off), rx_valid, 1'b0);
      repeat (10) @(negedge clk);
    end

    // T4
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_glitch_no_valid", rx_valid, 1'b0);
    fork
      send_rx(8'h3C, 1'b0, s);
      rx_wait_valid(c);
    join
    check("t4_seen", (c >= 0), 1'b1);
    check("t4_data", rx_data, 8'h3C);
    check("t4_frame_err", rx_frame_err, 1'b1);
    repeat (200) @(negedge clk);
    check("t4_no_false_frame_data", rx_data, 8'h3C);
    check("t4_no_false_frame_ovr", rx_overrun, 1'b0);
    rx_ack_pulse();
    check("t4_ack_valid", rx_valid, 1'b0);
    check("t4_ack_ferr", rx_frame_err, 1'b0);

    // T5: the second frame starts on the same tick phase as the first, so completes d clk after its start
    fork
      send_rx(8'h11, 1'b1, s);
      rx_wait_valid(c);
    join
    check("t5a_first_seen", (c >= 0), 1'b1);
    d = c - s;
    while ((cyc - s) % 8 != 0) @(negedge clk);
    send_rx(8'h22, 1'b1, sb);
    while (cyc < sb + d) @(negedge clk);
    check("t5a_data", rx_data, 8'h22);
    check("t5a_valid", rx_valid, 1'b1);
    check("t5a_overrun", rx_overrun, 1'b1);
    rx_ack_pulse();
    check("t5a_ack_valid", rx_valid, 1'b0);
    check("t5a_ack_overrun", rx_overrun, 1'b0);
    repeat (20) @(negedge clk);

    fork
      send_rx(8'h11, 1'b1, s);
      rx_wait_valid(c);
    join
    check("t5b_first_seen", (c >= 0), 1'b1);
    d = c - s;
    while ((cyc - s) % 8 != 0) @(negedge clk);
    sb = cyc;
    fork
      send_rx(8'h22, 1'b1, s);
      begin
        while (cyc < sb + d - 1) @(negedge clk);
        check("t5b_before_completion", rx_data, 8'h11);
        rx_ack_pulse();
        check("t5b_data", rx_data, 8'h22);
        check("t5b_valid", rx_valid, 1'b1);
        check("t5b_overrun", rx_overrun, 1'b0);
      end
    join
    rx_ack_pulse();
    check("t5b_ack_valid", rx_valid, 1'b0);

    // T6: reset during data bit 3 (0 for 0xA5)
    tx_accept(8'hA5);
    wait_txd_fall(n);
    repeat (72) @(negedge clk);
    check("t6_bit3_low", txd, 1'b0);
    n_rst = 1'b0;
    #1;
    check("t6_async_txd", txd, 1'b1);
    check("t6_async_ready", tx_ready, 1'b1);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);
    tx_accept(8'h7E);
    chk_tx_frame(8'h7E, 1'b0, n);

    // stall during data bit 1 (0 for 0x81)
    tx_accept(8'h81);
    wait_txd_fall(n);
    repeat (40) @(negedge clk);
    stall = 1'b1;
    repeat (100) @(negedge clk);
    check("t6_stall_txd", txd, 1'b0);
    check("t6_stall_busy", tx_ready, 1'b0);
    stall = 1'b0;
    n = 0;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t6_resume_done", tx_ready, 1'b1);
    check("t6_resume_txd", txd, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
